// File: rtl/cr16_control_fsm_if.sv
// Control-side bundle between the CR16 controller, instruction memory and the datapath.
// master is the controller; slave is the memory/datapath side.
interface cr16_control_fsm_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [4:0]  flags;
  logic [3:0]  rdest_reg_loc;
  logic [3:0]  rsrc_reg_loc;
  logic [4:0]  op_code;
  logic [15:0] imm;
  logic        imm_s;
  logic        en;
  logic [4:0]  psr;
  logic        halted;

  modport master (
    input  instr, instr_valid, flags,
    output instr_ready, pc, rdest_reg_loc, rsrc_reg_loc, op_code, imm, imm_s, en, psr, halted
  );

  modport slave (
    output instr, instr_valid, flags,
    input  instr_ready, pc, rdest_reg_loc, rsrc_reg_loc, op_code, imm, imm_s, en, psr, halted
  );
endinterface

// File: rtl/cr16_control_fsm.sv
// Multicycle CR16 control unit: FETCH/DECODE/EXEC/WB sequencing, flag latching and branches.
// Every output is a flop; the output process computes their next values.
module cr16_control_fsm (
  input  logic                       clk,
  input  logic                       rst_n,
  cr16_control_fsm_if.master         bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

  localparam logic [4:0] OpAdd = 5'd0;
  localparam logic [4:0] OpSub = 5'd1;
  localparam logic [4:0] OpCmp = 5'd2;
  localparam logic [4:0] OpAnd = 5'd3;
  localparam logic [4:0] OpOr  = 5'd4;
  localparam logic [4:0] OpXor = 5'd5;
  localparam logic [4:0] OpMov = 5'd6;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [4:0]  psr_q, psr_d;
  logic [3:0]  rdest_q, rdest_d;
  logic [3:0]  rsrc_q, rsrc_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] imm_q, imm_d;
  logic        imm_s_q, imm_s_d;
  logic        en_q, en_d;
  logic        halted_q, halted_d;
  logic        instr_ready_q, instr_ready_d;

  logic        accept;
  logic [3:0]  code;
  logic        alu_ok;
  logic [4:0]  alu_op;
  logic        dec_imm_s;
  logic [15:0] dec_imm;
  logic        dec_write;
  logic        dec_flags;
  logic        dec_branch;
  logic        dec_halt;
  logic        taken;

  assign accept = (state_q == StFetch) && instr_ready_q && bus.instr_valid;

  // Register format takes its op from IR[7:4]; immediate format reuses the same codes in IR[15:12].
  always_comb begin
    code   = (ir_q[15:12] == 4'h0) ? ir_q[7:4] : ir_q[15:12];
    alu_ok = 1'b1;
    alu_op = OpAdd;
    case (code)
      4'h5:    alu_op = OpAdd;
      4'h9:    alu_op = OpSub;
      4'hB:    alu_op = OpCmp;
      4'h1:    alu_op = OpAnd;
      4'h2:    alu_op = OpOr;
      4'h3:    alu_op = OpXor;
      4'hD:    alu_op = OpMov;
      default: alu_ok = 1'b0;
    endcase
    dec_imm_s = alu_ok && (ir_q[15:12] != 4'h0);
    dec_imm   = 16'h0000;
    if (dec_imm_s) begin
      if (alu_op == OpAdd || alu_op == OpSub || alu_op == OpCmp) begin
        dec_imm = {{8{ir_q[7]}}, ir_q[7:0]};
      end else begin
        dec_imm = {8'h00, ir_q[7:0]};
      end
    end
    dec_write  = alu_ok && (alu_op != OpCmp);
    dec_flags  = alu_ok && (alu_op == OpAdd || alu_op == OpSub || alu_op == OpCmp);
    dec_branch = (ir_q[15:12] == 4'hC);
    dec_halt   = (ir_q[15:12] == 4'hF);
    case (ir_q[11:8])
      4'h0:    taken = psr_q[1];
      4'h1:    taken = ~psr_q[1];
      4'h6:    taken = psr_q[0];
      4'hE:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      ir_q          <= 16'h0000;
      pc_q          <= 16'h0000;
      psr_q         <= 5'h00;
      rdest_q       <= 4'h0;
      rsrc_q        <= 4'h0;
      op_q          <= 5'h00;
      imm_q         <= 16'h0000;
      imm_s_q       <= 1'b0;
      en_q          <= 1'b0;
      halted_q      <= 1'b0;
      instr_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      pc_q          <= pc_d;
      psr_q         <= psr_d;
      rdest_q       <= rdest_d;
      rsrc_q        <= rsrc_d;
      op_q          <= op_d;
      imm_q         <= imm_d;
      imm_s_q       <= imm_s_d;
      en_q          <= en_d;
      halted_q      <= halted_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (accept) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = dec_halt ? StHalt : StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    ir_d          = ir_q;
    pc_d          = pc_q;
    psr_d         = psr_q;
    rdest_d       = rdest_q;
    rsrc_d        = rsrc_q;
    op_d          = op_q;
    imm_d         = imm_q;
    imm_s_d       = imm_s_q;
    en_d          = 1'b0;
    instr_ready_d = (state_d == StFetch);
    halted_d      = (state_d == StHalt);
    case (state_q)
      StFetch: if (accept) ir_d = bus.instr;
      StDecode: begin
        rdest_d = ir_q[11:8];
        rsrc_d  = ir_q[3:0];
        op_d    = alu_ok ? alu_op : OpAdd;
        imm_d   = dec_imm;
        imm_s_d = dec_imm_s;
      end
      // En is set up one edge early so it is high for exactly the WB cycle.
      StExec: en_d = dec_write;
      StWb: begin
        if (dec_flags) psr_d = bus.flags;
        pc_d = (dec_branch && taken) ? pc_q + {{8{ir_q[7]}}, ir_q[7:0]} : pc_q + 16'h0001;
      end
      default: ;
    endcase
  end

  assign bus.instr_ready   = instr_ready_q;
  assign bus.pc            = pc_q;
  assign bus.rdest_reg_loc = rdest_q;
  assign bus.rsrc_reg_loc  = rsrc_q;
  assign bus.op_code       = op_q;
  assign bus.imm           = imm_q;
  assign bus.imm_s         = imm_s_q;
  assign bus.en            = en_q;
  assign bus.psr           = psr_q;
  assign bus.halted        = halted_q;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed bench for cr16_control_fsm: hand-computed expectations checked with immediate asserts.
module tb_cr16_control_fsm;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  cr16_control_fsm_if bus ();

  cr16_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one instruction in FETCH; returns in DECODE with Instr scrambled.
  task automatic accept(input logic [15:0] word, input logic [4:0] f);
    chk("ready_before_accept", {15'd0, bus.instr_ready}, 16'h0001);
    bus.instr       = word;
    bus.flags       = f;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hDEAD;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},     bus.pc, 16'h0000);
    chk({tag, "_rdest"},  {12'd0, bus.rdest_reg_loc}, 16'h0000);
    chk({tag, "_rsrc"},   {12'd0, bus.rsrc_reg_loc}, 16'h0000);
    chk({tag, "_op"},     {11'd0, bus.op_code}, 16'h0000);
    chk({tag, "_imm"},    bus.imm, 16'h0000);
    chk({tag, "_imm_s"},  {15'd0, bus.imm_s}, 16'h0000);
    chk({tag, "_en"},     {15'd0, bus.en}, 16'h0000);
    chk({tag, "_psr"},    {11'd0, bus.psr}, 16'h0000);
    chk({tag, "_halted"}, {15'd0, bus.halted}, 16'h0000);
    chk({tag, "_ready"},  {15'd0, bus.instr_ready}, 16'h0000);
  endtask

  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    chk({tag, "_ready_at_release"}, {15'd0, bus.instr_ready}, 16'h0000);
    tick();
    chk({tag, "_ready_after_1"}, {15'd0, bus.instr_ready}, 16'h0001);
  endtask

  initial begin
    passed          = 0;
    total           = 0;
    rst_n           = 1'b0;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.flags       = 5'h00;
    #1;
    chk_reset_outputs("por");
    tick();
    tick();
    release_reset("por");

    // ADDI r3, #5 at PC=0
    accept(16'h5305, 5'b00001);
    chk("addi_en_decode", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("addi_rdest", {12'd0, bus.rdest_reg_loc}, 16'h0003);
    chk("addi_imm",   bus.imm, 16'h0005);
    chk("addi_imm_s", {15'd0, bus.imm_s}, 16'h0001);
    chk("addi_op",    {11'd0, bus.op_code}, 16'h0000);
    chk("addi_en_exec", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("addi_en_wb", {15'd0, bus.en}, 16'h0001);
    tick();
    chk("addi_en_after", {15'd0, bus.en}, 16'h0000);
    chk("addi_psr", {11'd0, bus.psr}, 16'h0001);
    chk("addi_pc",  bus.pc, 16'h0001);

    // SUBI sign extension
    accept(16'h91FF, 5'b10000);
    tick();
    chk("subi_imm", bus.imm, 16'hFFFF);
    chk("subi_op",  {11'd0, bus.op_code}, 16'h0001);
    tick();
    chk("subi_en_wb", {15'd0, bus.en}, 16'h0001);
    tick();
    chk("subi_psr", {11'd0, bus.psr}, 16'h0010);
    chk("subi_pc",  bus.pc, 16'h0002);

    // ANDI zero extension, flags not latched
    accept(16'h12FF, 5'b00111);
    tick();
    chk("andi_imm", bus.imm, 16'h00FF);
    chk("andi_op",  {11'd0, bus.op_code}, 16'h0003);
    chk("andi_rdest", {12'd0, bus.rdest_reg_loc}, 16'h0002);
    tick();
    chk("andi_en_wb", {15'd0, bus.en}, 16'h0001);
    tick();
    chk("andi_psr_kept", {11'd0, bus.psr}, 16'h0010);
    chk("andi_pc", bus.pc, 16'h0003);

    // CMP r1, r2 register format
    accept(16'h01B2, 5'b00010);
    tick();
    chk("cmp_op",    {11'd0, bus.op_code}, 16'h0002);
    chk("cmp_rsrc",  {12'd0, bus.rsrc_reg_loc}, 16'h0002);
    chk("cmp_rdest", {12'd0, bus.rdest_reg_loc}, 16'h0001);
    chk("cmp_imm_s", {15'd0, bus.imm_s}, 16'h0000);
    chk("cmp_imm",   bus.imm, 16'h0000);
    tick();
    chk("cmp_en_wb", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("cmp_psr", {11'd0, bus.psr}, 16'h0002);
    chk("cmp_pc",  bus.pc, 16'h0004);

    // Undefined register-format op is a NOP
    accept(16'h0000, 5'b11111);
    tick();
    tick();
    chk("nop_en_wb", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("nop_psr", {11'd0, bus.psr}, 16'h0002);
    chk("nop_pc",  bus.pc, 16'h0005);

    // BEQ -2 taken at PC=5 with Z=1
    accept(16'hC0FE, 5'b00000);
    tick();
    chk("beq_t_en_exec", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("beq_t_en_wb", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("beq_t_pc", bus.pc, 16'h0003);
    chk("beq_t_psr", {11'd0, bus.psr}, 16'h0002);

    // Clear Z with ADDI, step to PC=5, BEQ not taken
    accept(16'h5305, 5'b00000);
    tick();
    tick();
    tick();
    chk("clr_psr", {11'd0, bus.psr}, 16'h0000);
    accept(16'h0000, 5'b00000);
    tick();
    tick();
    tick();
    chk("nop2_pc", bus.pc, 16'h0005);
    accept(16'hC0FE, 5'b00010);
    tick();
    tick();
    chk("beq_nt_en_wb", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("beq_nt_pc", bus.pc, 16'h0006);

    // Reset held mid-EXEC
    accept(16'h0351, 5'b00001);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_exec");
    tick();
    tick();
    chk("rst_exec_hold_en", {15'd0, bus.en}, 16'h0000);
    release_reset("rst_exec");

    // Reset during WB kills En at once
    accept(16'h5305, 5'b00001);
    tick();
    tick();
    chk("rst_wb_en_before", {15'd0, bus.en}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_en_cleared", {15'd0, bus.en}, 16'h0000);
    chk("rst_wb_pc", bus.pc, 16'h0000);
    chk("rst_wb_psr", {11'd0, bus.psr}, 16'h0000);
    tick();
    release_reset("rst_wb");

    // BR UC -2 from PC=0 wraps
    accept(16'hCEFE, 5'b00000);
    tick();
    tick();
    chk("buc_en_wb", {15'd0, bus.en}, 16'h0000);
    tick();
    chk("buc_pc", bus.pc, 16'hFFFE);

    // Stall in FETCH for 10 cycles
    bus.instr = 16'h5305;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_pc", bus.pc, 16'hFFFE);
    chk("stall_ready", {15'd0, bus.instr_ready}, 16'h0001);
    chk("stall_en", {15'd0, bus.en}, 16'h0000);
    chk("stall_rdest", {12'd0, bus.rdest_reg_loc}, 16'h000E);

    accept(16'h0000, 5'b00000);
    tick();
    tick();
    tick();
    chk("nop3_pc", bus.pc, 16'hFFFF);

    // HALT at 0xFFFF: PC wraps to 0, then parked
    accept(16'hF000, 5'b00000);
    tick();
    tick();
    chk("halt_en_wb", {15'd0, bus.en}, 16'h0000);
    chk("halt_not_yet", {15'd0, bus.halted}, 16'h0000);
    tick();
    chk("halt_halted", {15'd0, bus.halted}, 16'h0001);
    chk("halt_ready", {15'd0, bus.instr_ready}, 16'h0000);
    chk("halt_pc_wrap", bus.pc, 16'h0000);
    bus.instr       = 16'h5305;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("halt_stays", {15'd0, bus.halted}, 16'h0001);
    chk("halt_ready_stays", {15'd0, bus.instr_ready}, 16'h0000);
    chk("halt_pc_stays", bus.pc, 16'h0000);
    chk("halt_en_stays", {15'd0, bus.en}, 16'h0000);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_cleared", {15'd0, bus.halted}, 16'h0000);
    tick();
    release_reset("halt_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cr16_control_fsm.md
# cr16_control_fsm

Multicycle control unit that sequences the register-file/ALU datapath. Fetches 16-bit instructions over a valid/ready handshake, decodes them, and drives the datapath's register selects, ALU opcode, immediate value, immediate select and register write enable. It latches ALU flags into a processor status register and resolves conditional branches against it. Sits between instruction memory and the datapath, on the control side of the datapath's control interface.

## Interface
- No parameters.
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Instr  in  16  instruction word from instruction memory.
- InstrValid  in  1  Instr is valid this cycle.
- InstrReady  out  1  controller is accepting an instruction.
- PC  out  16  address of the current or next instruction.
- Flags  in  5  live ALU flags: [4]C, [3]L, [2]F, [1]Z, [0]N.
- RdestRegLoc  out  4  destination/first-operand register select.
- RsrcRegLoc  out  4  source register select.
- OpCode  out  5  ALU op: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, MOV=6.
- Imm  out  16  extended immediate.
- Imm_s  out  1  1 selects Imm as the ALU source; 0 selects RsrcOut.
- En  out  1  register-file write enable.
- Psr  out  5  latched flags, same bit order as Flags.
- Halted  out  1  HALT executed.

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT. All outputs are registered.
- FETCH:
  - InstrReady=1.
  - When InstrValid=1, capture Instr into IR and go to DECODE.
  - Otherwise remain in FETCH with no limit.
- DECODE: load RdestRegLoc=IR[11:8], RsrcRegLoc=IR[3:0], OpCode, Imm and Imm_s. These hold unchanged through WB.
- Register format (IR[15:12]=0000), IR[7:4] selects the op:
  - 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
  - Imm_s=0, Imm=0.
- Immediate format (IR[15:12] is one of the codes above), Imm_s=1:
  - ADDI/SUBI/CMPI: Imm = sign-extended IR[7:0].
  - ANDI/ORI/XORI/MOVI: Imm = zero-extended IR[7:0].
- Bcond (IR[15:12]=1100):
  - Condition in IR[11:8]: 0000 EQ (Z=1), 0001 NE (Z=0), 0110 GT (N=1), 1110 UC (always). Any other code is never taken.
  - Displacement = IR[7:0], signed.
- HALT: IR[15:12]=1111.
- Any other encoding, including an undefined register-format IR[7:4], is a NOP.
- EXEC: one settle cycle for the ALU. No output changes.
- WB:
  - En=1 for exactly this cycle for ADD, SUB, AND, OR, XOR, MOV and their immediate forms.
  - En stays 0 for CMP, branches and NOPs.
  - Psr<=Flags for ADD, SUB, CMP and their immediate forms. All other ops leave Psr unchanged.
  - PC <= PC + sext(disp) for a taken branch, otherwise PC+1.
  - Next state is FETCH, or HALT if IR is HALT.
- HALT: InstrReady=0, En=0, Halted=1. Only reset leaves this state.
- PC and branch arithmetic are modulo 2^16: 16'hFFFF+1 = 16'h0000, and 16'h0000 + (-2) = 16'hFFFE.
- A branch evaluates Psr as it stands at WB, i.e. the flags from the last flag-setting instruction.

## Timing
- Reset (Rst=0), applied immediately and asynchronously:
  - state=FETCH; PC, IR, Psr, RdestRegLoc, RsrcRegLoc, OpCode and Imm = 0.
  - Imm_s=0, En=0, Halted=0, InstrReady=0.
  - InstrReady rises 1 cycle after Rst deasserts.
- Accepting an instruction on edge N gives: DECODE during cycle N+1, EXEC during N+2, WB (En high) during N+3, and FETCH with the new PC during N+4.
- Throughput: 4 cycles per instruction when InstrValid is held high.
- Instr is sampled only on the edge where InstrValid and InstrReady are both 1. InstrValid in any other state is ignored.
- Reset during WB drops En combinationally through the async clear; no register write may occur.
- En is never high in two consecutive cycles.

## Test plan
- Reset: hold Rst=0 mid-EXEC → all outputs at reset values, PC=0. Release → InstrReady=1 one cycle later.
- ADDI: Instr=16'h5305 at PC=0 → RdestRegLoc=3, Imm=16'h0005, Imm_s=1, OpCode=0. En high exactly in cycle N+3. Psr=Flags (drive 5'b00001 → Psr=5'b00001). PC=1.
- SUBI / ANDI extension:
  - 16'h91FF → Imm=16'hFFFF, OpCode=1.
  - 16'h12FF → Imm=16'h00FF, OpCode=3, Psr unchanged.
- CMP: 16'h01B2 with Flags=5'b00010 → OpCode=2, RsrcRegLoc=2, Imm_s=0. En never asserted. Psr=5'b00010.
- Branch: PC=5, Instr=16'hC0FE:
  - Psr.Z=1 → PC=3.
  - Psr.Z=0 → PC=6.
  - With PC=0 and UC 16'hCEFE → PC=16'hFFFE.
  - En=0 throughout.
- HALT plus stall: InstrValid=0 for 10 cycles → PC and state unchanged. Then 16'hF000 → Halted=1, InstrReady=0 indefinitely, cleared only by Rst=0.
